// File: rtl/nbit_divide_unit.sv
// nbit_divide_unit
//
// Sequential restoring divider: a 2N-bit dividend divided by an N-bit
// divisor, one quotient bit per clock, with a Start/Done handshake.
// Divide-by-zero and quotient-overflow are detected when the operands are
// captured and short-circuit the iteration.
//
// Optional feature macro: SIGNED_DIV_EN
//   Adds the SignedMode input and the FIXUP state. Signed operands are
//   converted to magnitudes, divided unsigned, then the signs are applied
//   to the quotient and remainder in FIXUP.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   Reset      synchronous active-high reset
//   Start      request; sampled only in IDLE
//   Dividend   2N-bit dividend, captured on the accepting edge
//   Divisor    N-bit divisor, captured on the accepting edge
//   SignedMode two's complement operands (SIGNED_DIV_EN only)
//   Quotient   registered N-bit quotient
//   Remainder  registered N-bit remainder
//   Done       one-cycle pulse when the result registers update
//   Busy       high from the accepting edge until the return to IDLE
//   DivZero    registered divide-by-zero flag
//   Overflow   registered quotient-overflow flag
module nbit_divide_unit #(
  parameter int N = 8
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Start,
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
`ifdef SIGNED_DIV_EN
  input  logic           SignedMode,
`endif
  output logic [N-1:0]   Quotient,
  output logic [N-1:0]   Remainder,
  output logic           Done,
  output logic           Busy,
  output logic           DivZero,
  output logic           Overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  // Two's complement negation helpers (magnitude extraction / sign apply)
  function automatic logic [2*N-1:0] neg_wide(input logic [2*N-1:0] v);
    return ~v + {{(2*N-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [N-1:0] neg_narrow(input logic [N-1:0] v);
    return ~v + {{(N-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N:0]      rem_q;     // partial remainder
  logic [N-1:0]    lo_q;      // dividend low half, quotient shifts in at LSB
  logic [N-1:0]    dvs_q;     // divisor magnitude
  logic            dz_q;
  logic            ov_q;
  logic [N-1:0]    quo_q;
  logic [N-1:0]    rmd_q;
  logic            done_q;
  logic            busy_q;
  logic            dzo_q;
  logic            ovo_q;
`ifdef SIGNED_DIV_EN
  logic            sm_q;
  logic            negq_q;
  logic            negr_q;
`endif

  // Operand sign handling at capture
  logic            sm_in;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [2*N-1:0]  dvd_mag;
  logic [N-1:0]    dvs_mag;
  logic            cap_dz;
  logic            cap_ov;

`ifdef SIGNED_DIV_EN
  assign sm_in = SignedMode;
`else
  assign sm_in = 1'b0;
`endif

  always_comb begin
    dvd_neg = sm_in & Dividend[2*N-1];
    dvs_neg = sm_in & Divisor[N-1];
    dvd_mag = dvd_neg ? neg_wide(Dividend) : Dividend;
    dvs_mag = dvs_neg ? neg_narrow(Divisor) : Divisor;
    cap_dz  = (Divisor == '0);
    // A high half not below the divisor means the quotient needs > N bits
    cap_ov  = !cap_dz && (dvd_mag[2*N-1:N] >= dvs_mag);
  end

  // One restoring iteration
  logic [N:0]      shifted;
  logic [N+1:0]    diff;
  logic            qbit;
  logic [N:0]      rem_d;
  logic [N-1:0]    lo_d;

  always_comb begin
    shifted = {rem_q[N-1:0], lo_q[N-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    qbit    = ~diff[N+1];
    rem_d   = qbit ? diff[N:0] : shifted;
    lo_d    = {lo_q[N-2:0], qbit};
  end

`ifdef SIGNED_DIV_EN
  logic [N-1:0]    fix_quo;
  logic [N-1:0]    fix_rmd;
  logic            fix_ov;

  always_comb begin
    fix_quo = negq_q ? neg_narrow(lo_q) : lo_q;
    fix_rmd = negr_q ? neg_narrow(rem_q[N-1:0]) : rem_q[N-1:0];
    // Negative results may reach -2^(N-1); positive ones stop at 2^(N-1)-1
    fix_ov  = sm_q & lo_q[N-1] & (negq_q ? (|lo_q[N-2:0]) : 1'b1);
  end
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dzo_q   <= 1'b0;
      ovo_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            rem_q   <= {1'b0, dvd_mag[2*N-1:N]};
            lo_q    <= cap_dz ? Dividend[N-1:0] : dvd_mag[N-1:0];
            dvs_q   <= dvs_mag;
            dz_q    <= cap_dz;
            ov_q    <= cap_ov;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef SIGNED_DIV_EN
            sm_q    <= sm_in;
            negq_q  <= dvd_neg ^ dvs_neg;
            negr_q  <= dvd_neg;
`endif
          end
        end
        S_RUN: begin
          if (dz_q || ov_q) begin
            // Exceptions skip the iterations entirely
            quo_q   <= '1;
            rmd_q   <= dz_q ? lo_q : '0;
            dzo_q   <= dz_q;
            ovo_q   <= ov_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rem_q <= rem_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
`ifdef SIGNED_DIV_EN
              state_q <= S_FIXUP;
`else
              quo_q   <= lo_d;
              rmd_q   <= rem_d[N-1:0];
              dzo_q   <= 1'b0;
              ovo_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef SIGNED_DIV_EN
        S_FIXUP: begin
          quo_q   <= fix_ov ? '1 : fix_quo;
          rmd_q   <= fix_ov ? '0 : fix_rmd;
          dzo_q   <= 1'b0;
          ovo_q   <= fix_ov;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign DivZero   = dzo_q;
  assign Overflow  = ovo_q;

endmodule

// File: tb/tb_nbit_divide_unit.sv
// Directed testbench for nbit_divide_unit: an N=8 and an N=4 instance
// share clock and reset; expected values are hand-computed constants.
module tb_nbit_divide_unit;

`ifdef SIGNED_DIV_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT8 = 8 + EXTRA;
  localparam int LAT4 = 4 + EXTRA;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start8 = 1'b0;
  logic [15:0] Dividend8 = '0;
  logic [7:0]  Divisor8 = '0;
  logic [7:0]  Quotient8, Remainder8;
  logic        Done8, Busy8, DivZero8, Overflow8;
  logic        Start4 = 1'b0;
  logic [7:0]  Dividend4 = '0;
  logic [3:0]  Divisor4 = '0;
  logic [3:0]  Quotient4, Remainder4;
  logic        Done4, Busy4, DivZero4, Overflow4;
`ifdef SIGNED_DIV_EN
  logic        Sm8 = 1'b0;
  logic        Sm4 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int dcount;

  always #5 CLK = ~CLK;

  nbit_divide_unit #(.N(8)) u8 (
    .CLK(CLK), .Reset(Reset), .Start(Start8),
    .Dividend(Dividend8), .Divisor(Divisor8),
`ifdef SIGNED_DIV_EN
    .SignedMode(Sm8),
`endif
    .Quotient(Quotient8), .Remainder(Remainder8), .Done(Done8),
    .Busy(Busy8), .DivZero(DivZero8), .Overflow(Overflow8)
  );

  nbit_divide_unit #(.N(4)) u4 (
    .CLK(CLK), .Reset(Reset), .Start(Start4),
    .Dividend(Dividend4), .Divisor(Divisor4),
`ifdef SIGNED_DIV_EN
    .SignedMode(Sm4),
`endif
    .Quotient(Quotient4), .Remainder(Remainder4), .Done(Done4),
    .Busy(Busy4), .DivZero(DivZero4), .Overflow(Overflow4)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands with Start for one accepting edge (edge 0)
  task automatic start8(input logic [15:0] dvd, input logic [7:0] dvs);
    Dividend8 = dvd;
    Divisor8  = dvs;
    Start8    = 1'b1;
    tick();
    Start8    = 1'b0;
  endtask

  task automatic chk8(input string tag, input logic [7:0] q, input logic [7:0] r,
                      input logic dz, input logic ov);
    chk({tag, "_done"}, {31'd0, Done8}, 32'd1);
    chk({tag, "_quo"}, {24'd0, Quotient8}, {24'd0, q});
    chk({tag, "_rem"}, {24'd0, Remainder8}, {24'd0, r});
    chk({tag, "_dz"}, {31'd0, DivZero8}, {31'd0, dz});
    chk({tag, "_ov"}, {31'd0, Overflow8}, {31'd0, ov});
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_quo", {24'd0, Quotient8}, 32'd0);
    chk("rst_rem", {24'd0, Remainder8}, 32'd0);
    chk("rst_flags", {28'd0, Done8, Busy8, DivZero8, Overflow8}, 32'd0);
    chk("rst_n4", {16'd0, Quotient4, Remainder4, Done4, Busy4, DivZero4, Overflow4, 4'd0}, 32'd0);

    // Reset wins over Start
    Start8 = 1'b1;
    Dividend8 = 16'd1000;
    Divisor8 = 8'd7;
    tick();
    chk("rst_start_busy", {31'd0, Busy8}, 32'd0);
    Start8 = 1'b0;
    Reset = 1'b0;
    tick();

    // 1000 / 7 = 142 r 6
    start8(16'd1000, 8'd7);
    chk("u1_busy0", {31'd0, Busy8}, 32'd1);
    Dividend8 = 16'hAAAA;
    Divisor8 = 8'd1;
    for (int i = 1; i < LAT8; i++) tick();
    chk("u1_early_done", {31'd0, Done8}, 32'd0);
    chk("u1_hidden_quo", {24'd0, Quotient8}, 32'd0);
    tick();
    chk8("u1", 8'd142, 8'd6, 1'b0, 1'b0);
    chk("u1_busy_at_done", {31'd0, Busy8}, 32'd1);
    tick();
    chk("u1_done_pulse", {31'd0, Done8}, 32'd0);
    chk("u1_busy_low", {31'd0, Busy8}, 32'd0);
    chk("u1_hold_quo", {24'd0, Quotient8}, 32'd142);

    // Overflow: 0x0500 / 3
    start8(16'h0500, 8'd3);
    tick();
    chk8("ovf", 8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
    chk("ovf_busy_low", {31'd0, Busy8}, 32'd0);

    // Divide by zero: 0x1234 / 0
    start8(16'h1234, 8'd0);
    tick();
    chk8("dz", 8'hFF, 8'h34, 1'b1, 1'b0);
    tick();

    // Largest non-overflowing case: 0xFEFF / 0xFF = 255 r 254 (unsigned)
`ifndef SIGNED_DIV_EN
    start8(16'hFEFF, 8'hFF);
    for (int i = 0; i < LAT8; i++) tick();
    chk8("max", 8'd255, 8'd254, 1'b0, 1'b0);
    tick();
    // Upper half equal to the divisor is an overflow
    start8(16'hFF00, 8'hFF);
    tick();
    chk8("eq_ovf", 8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
`endif

    // Start while busy is ignored
    start8(16'd1000, 8'd7);
    tick();
    tick();
    Dividend8 = 16'd50;
    Divisor8 = 8'd5;
    Start8 = 1'b1;
    dcount = 0;
    tick();
    Start8 = 1'b0;
    if (Done8) dcount++;
    for (int i = 4; i <= LAT8 + 4; i++) begin
      tick();
      if (Done8) dcount++;
    end
    chk("busy_ign_count", dcount, 32'd1);
    chk("busy_ign_quo", {24'd0, Quotient8}, 32'd142);
    chk("busy_ign_rem", {24'd0, Remainder8}, 32'd6);

    // Reset mid-operation aborts without Done
    start8(16'd50, 8'd5);
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_quo", {24'd0, Quotient8}, 32'd0);
    chk("abort_rem", {24'd0, Remainder8}, 32'd0);
    chk("abort_flags", {28'd0, Done8, Busy8, DivZero8, Overflow8}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done8 || Busy8) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);

    // Back-to-back: Start held; second accept at edge N+2 sees new operands
    Dividend8 = 16'd100;
    Divisor8 = 8'd10;
    Start8 = 1'b1;
    tick();
    Dividend8 = 16'd200;
    for (int i = 0; i < LAT8; i++) tick();
    chk8("b2b_first", 8'd10, 8'd0, 1'b0, 1'b0);
    tick();
    chk("b2b_idle_busy", {31'd0, Busy8}, 32'd0);
    tick();
    Start8 = 1'b0;
    chk("b2b_reaccept", {31'd0, Busy8}, 32'd1);
    for (int i = 0; i < LAT8; i++) tick();
    chk8("b2b_second", 8'd20, 8'd0, 1'b0, 1'b0);
    tick();

    // N=4: 55 / 9 = 6 r 1
    Dividend4 = 8'd55;
    Divisor4 = 4'd9;
    Start4 = 1'b1;
    tick();
    Start4 = 1'b0;
    for (int i = 1; i < LAT4; i++) tick();
    chk("n4_early_done", {31'd0, Done4}, 32'd0);
    tick();
    chk("n4_done", {31'd0, Done4}, 32'd1);
    chk("n4_quo", {28'd0, Quotient4}, 32'd6);
    chk("n4_rem", {28'd0, Remainder4}, 32'd1);
    chk("n4_flags", {30'd0, DivZero4, Overflow4}, 32'd0);
    tick();

`ifdef SIGNED_DIV_EN
    // -100 / 7 = -14 r -2
    Sm8 = 1'b1;
    start8(16'hFF9C, 8'd7);
    for (int i = 1; i < LAT8; i++) tick();
    chk("s_early_done", {31'd0, Done8}, 32'd0);
    tick();
    chk8("s_neg", 8'hF2, 8'hFE, 1'b0, 1'b0);
    tick();
    // -128 / 1 fits, 128 / 1 does not
    start8(16'hFF80, 8'd1);
    for (int i = 0; i < LAT8; i++) tick();
    chk8("s_min", 8'h80, 8'h00, 1'b0, 1'b0);
    tick();
    start8(16'h0080, 8'd1);
    for (int i = 0; i < LAT8; i++) tick();
    chk8("s_ovf", 8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
    Sm8 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
